// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings and parameter defaults.
package fetch_pkg;

    localparam int          PC_WIDTH_DEF = 16;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam logic [0:0]  RUN      = 1'b0;
    localparam logic [0:0]  RET_WAIT = 1'b1;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register that keeps an instruction word and its PC across a stall.
module fetch_hold_buffer
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                capture,
    input  logic                clear,
    input  logic [31:0]         data,
    input  logic [PC_WIDTH-1:0] data_pc,
    output logic                full,
    output logic [31:0]         word,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (capture) begin
            full <= 1'b1;
        end
    end

    // Payload is only meaningful while full is set, so it carries no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            word <= data;
            pc   <= data_pc;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, 1-cycle synchronous imem reads, stall skid, branch and return wait.
// Defining FETCH_PERF_COUNT_EN adds the perf_bubbles / perf_redirects counters.
module fetch
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]         NOP_WORD     = NOP_WORD_DEF
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                stall,
    input  logic                take_branch_address,
    input  logic [PC_WIDTH-1:0] branch_address,
    input  logic                ret,
    input  logic                ret_address_valid,
    input  logic [PC_WIDTH-1:0] ret_address,
    output logic                imem_ren,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction_word,
    output logic                instruction_valid,
    output logic [PC_WIDTH-1:0] instruction_pc
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]         perf_bubbles,
    output logic [15:0]         perf_redirects
`endif
);

    logic [0:0]          state;
    logic                started;
    logic [PC_WIDTH-1:0] pc;
    logic                pend_p1;
    logic [PC_WIDTH-1:0] pend_pc_p1;

    logic [31:0]         out_word_q;
    logic                out_valid_q;
    logic [PC_WIDTH-1:0] out_pc_q;

    logic                hold_full;
    logic [31:0]         hold_word;
    logic [PC_WIDTH-1:0] hold_pc;

    logic [31:0]         live_word;
    logic                live_valid;
    logic [PC_WIDTH-1:0] live_pc;

    logic run_go;
    logic do_branch;
    logic do_ret;
    logic do_resume;

    assign run_go    = !stall && (state == RUN);
    assign do_branch = run_go && take_branch_address;
    assign do_ret    = run_go && !take_branch_address && ret;
    assign do_resume = !stall && (state == RET_WAIT) && ret_address_valid;

    // The first cycle after reset release issues nothing, so the first word lands two edges later.
    assign imem_ren  = started && run_go && !take_branch_address && !ret;
    assign imem_addr = pc;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state   <= RUN;
            started <= 1'b0;
            pc      <= RESET_VECTOR;
            pend_p1 <= 1'b0;
        end else begin
            started <= 1'b1;
            pend_p1 <= imem_ren;
            if (do_branch) begin
                pc <= branch_address;
            end else if (do_resume) begin
                pc    <= ret_address;
                state <= RUN;
            end else if (do_ret) begin
                state <= RET_WAIT;
            end else if (imem_ren) begin
                pc <= pc + PC_WIDTH'(1);
            end
        end
    end

    // ---- read-data stage: PC of the word arriving on imem_rdata ----
    always_ff @(posedge clock) begin
        pend_pc_p1 <= pc;
    end

    fetch_hold_buffer #(
        .PC_WIDTH (PC_WIDTH)
    ) u_hold (
        .clock   (clock),
        .nreset  (nreset),
        .capture (stall && pend_p1 && !hold_full),
        .clear   (!stall && hold_full),
        .data    (imem_rdata),
        .data_pc (pend_pc_p1),
        .full    (hold_full),
        .word    (hold_word),
        .pc      (hold_pc)
    );

    // A word parked during a stall always goes out ahead of anything newer.
    always_comb begin
        live_word  = NOP_WORD;
        live_valid = 1'b0;
        live_pc    = out_pc_q;
        if (hold_full) begin
            live_word  = hold_word;
            live_valid = 1'b1;
            live_pc    = hold_pc;
        end else if (pend_p1) begin
            live_word  = imem_rdata;
            live_valid = 1'b1;
            live_pc    = pend_pc_p1;
        end
    end

    assign instruction_word  = stall ? out_word_q  : live_word;
    assign instruction_valid = stall ? out_valid_q : live_valid;
    assign instruction_pc    = stall ? out_pc_q    : live_pc;

    // ---- output stage: last presented instruction, replayed while stalled ----
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_word_q  <= NOP_WORD;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_VECTOR;
        end else begin
            out_word_q  <= instruction_word;
            out_valid_q <= instruction_valid;
            out_pc_q    <= instruction_pc;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            if (!instruction_valid) begin
                perf_bubbles <= sat_inc32(perf_bubbles);
            end
            if (do_branch || do_resume) begin
                perf_redirects <= sat_inc16(perf_redirects);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus a randomized run against a stream-level reference model.
module tb_fetch;

    logic        clock;
    logic        nreset;
    logic        stall;
    logic        take_branch_address;
    logic [15:0] branch_address;
    logic        ret;
    logic        ret_address_valid;
    logic [15:0] ret_address;
    logic        imem_ren;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_word;
    logic        instruction_valid;
    logic [15:0] instruction_pc;

    logic        nreset2;
    logic        imem_ren2;
    logic [15:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] word2;
    logic        valid2;
    logic [15:0] pc2;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] perf_bubbles;
    logic [15:0] perf_redirects;
    logic [31:0] perf_bubbles2;
    logic [15:0] perf_redirects2;
`endif

    int total = 0;
    int bad   = 0;

    fetch dut (
        .clock               (clock),
        .nreset              (nreset),
        .stall               (stall),
        .take_branch_address (take_branch_address),
        .branch_address      (branch_address),
        .ret                 (ret),
        .ret_address_valid   (ret_address_valid),
        .ret_address         (ret_address),
        .imem_ren            (imem_ren),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .instruction_word    (instruction_word),
        .instruction_valid   (instruction_valid),
        .instruction_pc      (instruction_pc)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .perf_bubbles        (perf_bubbles),
        .perf_redirects      (perf_redirects)
`endif
    );

    fetch #(.RESET_VECTOR(16'hFFFE)) dut2 (
        .clock               (clock),
        .nreset              (nreset2),
        .stall               (1'b0),
        .take_branch_address (1'b0),
        .branch_address      (16'h0000),
        .ret                 (1'b0),
        .ret_address_valid   (1'b0),
        .ret_address         (16'h0000),
        .imem_ren            (imem_ren2),
        .imem_addr           (imem_addr2),
        .imem_rdata          (imem_rdata2),
        .instruction_word    (word2),
        .instruction_valid   (valid2),
        .instruction_pc      (pc2)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .perf_bubbles        (perf_bubbles2),
        .perf_redirects      (perf_redirects2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory holds 0xA000_0000 + address; cycles without a read return junk.
    always @(posedge clock) begin
        imem_rdata  <= imem_ren  ? (32'hA000_0000 + {16'h0, imem_addr})  : $urandom;
        imem_rdata2 <= imem_ren2 ? (32'hA000_0000 + {16'h0, imem_addr2}) : $urandom;
    end

    task automatic reset_and_release();
        @(negedge clock);
        nreset = 1'b0;
        stall = 1'b0; take_branch_address = 1'b0; branch_address = '0;
        ret = 1'b0; ret_address_valid = 1'b0; ret_address = '0;
        @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        nreset = 1'b0;
        stall = 1'b0; take_branch_address = 1'b0; ret = 1'b0; ret_address_valid = 1'b0;
        #2;
        total++;
        if ({imem_ren, imem_addr, instruction_valid, instruction_word, instruction_pc} !==
            {1'b0, 16'h0000, 1'b0, 32'h0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state: ren=%0b addr=%h valid=%0b word=%h pc=%h, want 0 0000 0 00000000 0000",
                     imem_ren, imem_addr, instruction_valid, instruction_word, instruction_pc);
        end
    endtask

    task automatic test_sequential();
        reset_and_release();
        #2;
        total++;
        if ({imem_ren, instruction_valid} !== 2'b00) begin
            bad++;
            $display("FAIL seq_release: ren=%0b valid=%0b, want 0 0", imem_ren, instruction_valid);
        end
        @(negedge clock); #2;
        total++;
        if ({imem_ren, imem_addr, instruction_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL seq_first_read: ren=%0b addr=%h valid=%0b, want 1 0000 0", imem_ren, imem_addr, instruction_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #2;
            total++;
            if ({instruction_valid, instruction_word, instruction_pc, imem_addr} !==
                {1'b1, 32'hA000_0000 + i, 16'(i), 16'(i + 1)}) begin
                bad++;
                $display("FAIL seq_stream[%0d]: valid=%0b word=%h pc=%h addr=%h, want 1 %h %h %h", i,
                         instruction_valid, instruction_word, instruction_pc, imem_addr,
                         32'hA000_0000 + i, 16'(i), 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        reset_and_release();
        repeat (6) @(negedge clock);
        #2;
        total++;
        if ({instruction_word, imem_addr} !== {32'hA000_0004, 16'h0005}) begin
            bad++;
            $display("FAIL stall_setup: word=%h addr=%h, want a0000004 0005", instruction_word, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            stall = 1'b1;
            #2;
            total++;
            if ({instruction_valid, instruction_word, instruction_pc, imem_ren, imem_addr} !==
                {1'b1, 32'hA000_0004, 16'h0004, 1'b0, 16'h0006}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%0b word=%h pc=%h ren=%0b addr=%h, want 1 a0000004 0004 0 0006",
                         i, instruction_valid, instruction_word, instruction_pc, imem_ren, imem_addr);
            end
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            stall = 1'b0;
            #2;
            total++;
            if ({instruction_valid, instruction_word, instruction_pc, imem_ren, imem_addr} !==
                {1'b1, 32'hA000_0005 + j, 16'(5 + j), 1'b1, 16'(6 + j)}) begin
                bad++;
                $display("FAIL stall_release[%0d]: valid=%0b word=%h pc=%h ren=%0b addr=%h, want 1 %h %h 1 %h", j,
                         instruction_valid, instruction_word, instruction_pc, imem_ren, imem_addr,
                         32'hA000_0005 + j, 16'(5 + j), 16'(6 + j));
            end
        end
    endtask

    task automatic test_branch();
        reset_and_release();
        repeat (9) @(negedge clock);
        take_branch_address = 1'b1;
        branch_address = 16'h0040;
        #2;
        total++;
        if ({imem_addr, instruction_word} !== {16'h0008, 32'hA000_0007}) begin
            bad++;
            $display("FAIL branch_setup: addr=%h word=%h, want 0008 a0000007", imem_addr, instruction_word);
        end
        @(negedge clock);
        take_branch_address = 1'b0;
        #2;
        total++;
        if ({instruction_valid, instruction_word, imem_ren, imem_addr} !== {1'b0, 32'h0, 1'b1, 16'h0040}) begin
            bad++;
            $display("FAIL branch_bubble: valid=%0b word=%h ren=%0b addr=%h, want 0 00000000 1 0040",
                     instruction_valid, instruction_word, imem_ren, imem_addr);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clock); #2;
            total++;
            if ({instruction_valid, instruction_word, instruction_pc} !== {1'b1, 32'hA000_0040 + j, 16'(16'h40 + j)}) begin
                bad++;
                $display("FAIL branch_target[%0d]: valid=%0b word=%h pc=%h, want 1 %h %h", j,
                         instruction_valid, instruction_word, instruction_pc, 32'hA000_0040 + j, 16'(16'h40 + j));
            end
        end
    endtask

    task automatic test_ret();
        reset_and_release();
        repeat (17) @(negedge clock);
        ret = 1'b1;
        ret_address_valid = 1'b1;
        ret_address = 16'h0099;
        #2;
        total++;
        if ({imem_addr, instruction_valid, instruction_word} !== {16'h0010, 1'b1, 32'hA000_000F}) begin
            bad++;
            $display("FAIL ret_setup: addr=%h valid=%0b word=%h, want 0010 1 a000000f", imem_addr, instruction_valid, instruction_word);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ret = 1'b0;
            ret_address_valid = (i == 3);
            ret_address = 16'h0022;
            #2;
            total++;
            if ({instruction_valid, instruction_word, imem_ren} !== {1'b0, 32'h0, 1'b0}) begin
                bad++;
                $display("FAIL ret_wait[%0d]: valid=%0b word=%h ren=%0b, want 0 00000000 0", i,
                         instruction_valid, instruction_word, imem_ren);
            end
        end
        @(negedge clock);
        ret_address_valid = 1'b0;
        #2;
        total++;
        if ({instruction_valid, imem_ren, imem_addr} !== {1'b0, 1'b1, 16'h0022}) begin
            bad++;
            $display("FAIL ret_resume: valid=%0b ren=%0b addr=%h, want 0 1 0022", instruction_valid, imem_ren, imem_addr);
        end
        @(negedge clock); #2;
        total++;
        if ({instruction_valid, instruction_word, instruction_pc} !== {1'b1, 32'hA000_0022, 16'h0022}) begin
            bad++;
            $display("FAIL ret_target: valid=%0b word=%h pc=%h, want 1 a0000022 0022", instruction_valid, instruction_word, instruction_pc);
        end
    endtask

    task automatic test_reset_mid_ret();
        reset_and_release();
        repeat (5) @(negedge clock);
        ret = 1'b1;
        @(negedge clock);
        ret = 1'b0;
        @(negedge clock);
        #2;
        nreset = 1'b0;
        #1;
        total++;
        if ({imem_ren, imem_addr, instruction_valid, instruction_word, instruction_pc} !==
            {1'b0, 16'h0000, 1'b0, 32'h0, 16'h0000}) begin
            bad++;
            $display("FAIL midret_async_reset: ren=%0b addr=%h valid=%0b word=%h pc=%h, want 0 0000 0 00000000 0000",
                     imem_ren, imem_addr, instruction_valid, instruction_word, instruction_pc);
        end
        @(negedge clock);
        nreset = 1'b1;
        ret_address_valid = 1'b1;
        ret_address = 16'h0077;
        @(negedge clock); #2;
        total++;
        if ({imem_ren, imem_addr} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL midret_restart: ren=%0b addr=%h, want 1 0000", imem_ren, imem_addr);
        end
        @(negedge clock); #2;
        ret_address_valid = 1'b0;
        total++;
        if ({instruction_valid, instruction_word, imem_addr} !== {1'b1, 32'hA000_0000, 16'h0001}) begin
            bad++;
            $display("FAIL midret_first: valid=%0b word=%h addr=%h, want 1 a0000000 0001", instruction_valid, instruction_word, imem_addr);
        end
    endtask

    task automatic test_reset_vector_wrap();
        logic [15:0] p;
        @(negedge clock);
        nreset2 = 1'b0;
        #2;
        total++;
        if ({imem_ren2, imem_addr2, valid2, pc2} !== {1'b0, 16'hFFFE, 1'b0, 16'hFFFE}) begin
            bad++;
            $display("FAIL rv_reset: ren=%0b addr=%h valid=%0b pc=%h, want 0 fffe 0 fffe", imem_ren2, imem_addr2, valid2, pc2);
        end
        @(negedge clock);
        nreset2 = 1'b1;
        @(negedge clock); #2;
        total++;
        if ({imem_ren2, imem_addr2} !== {1'b1, 16'hFFFE}) begin
            bad++;
            $display("FAIL rv_first_read: ren=%0b addr=%h, want 1 fffe", imem_ren2, imem_addr2);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clock); #2;
            p = 16'hFFFE + 16'(j);
            total++;
            if ({valid2, word2, pc2, imem_addr2} !== {1'b1, 32'hA000_0000 + {16'h0, p}, p, p + 16'd1}) begin
                bad++;
                $display("FAIL rv_wrap[%0d]: valid=%0b word=%h pc=%h addr=%h, want 1 %h %h %h", j,
                         valid2, word2, pc2, imem_addr2, 32'hA000_0000 + {16'h0, p}, p, p + 16'd1);
            end
        end
    endtask

    // Reference: reads are issued from next_pc in program order and each comes out on the
    // next unstalled cycle; redirects discard whatever is still queued.
    task automatic test_random();
        int          q[$];
        bit          m_started;
        bit          m_waiting;
        logic [15:0] m_next;
        logic [31:0] last_word;
        logic        last_valid;
        logic [15:0] last_pc;
        logic [31:0] e_word;
        logic        e_valid;
        logic [15:0] e_pc;
        bit          ren_known;
        logic        e_ren;

        reset_and_release();
        m_started = 0; m_waiting = 0; m_next = 16'h0000;
        last_word = 32'h0; last_valid = 1'b0; last_pc = 16'h0000;
        for (int c = 0; c < 600; c++) begin
            stall               = ($urandom_range(0, 3) == 0);
            take_branch_address = ($urandom_range(0, 11) == 0);
            branch_address      = 16'($urandom);
            ret                 = ($urandom_range(0, 15) == 0);
            ret_address_valid   = ($urandom_range(0, 2) == 0);
            ret_address         = 16'($urandom);
            #2;
            if (stall) begin
                e_word = last_word; e_valid = last_valid; e_pc = last_pc;
            end else if (q.size() > 0) begin
                e_word = 32'hA000_0000 + q[0]; e_valid = 1'b1; e_pc = 16'(q[0]);
            end else begin
                e_word = 32'h0; e_valid = 1'b0; e_pc = last_pc;
            end
            ren_known = 1; e_ren = 1'b1;
            if (stall || m_waiting || !m_started) e_ren = 1'b0;
            else if (take_branch_address || ret) ren_known = 0;

            total++;
            if (instruction_valid !== e_valid ||
                (e_valid && {instruction_word, instruction_pc} !== {e_word, e_pc})) begin
                bad++;
                $display("FAIL rand_out[%0d]: valid=%0b word=%h pc=%h, want %0b %h %h", c,
                         instruction_valid, instruction_word, instruction_pc, e_valid, e_word, e_pc);
            end
            if (ren_known) begin
                total++;
                if (imem_ren !== e_ren || (e_ren && imem_addr !== m_next)) begin
                    bad++;
                    $display("FAIL rand_read[%0d]: ren=%0b addr=%h, want %0b %h", c, imem_ren, imem_addr, e_ren, m_next);
                end
            end

            if (!stall) begin
                last_word = e_word; last_valid = e_valid; last_pc = e_pc;
                if (q.size() > 0) void'(q.pop_front());
                if (m_waiting) begin
                    if (ret_address_valid) begin
                        m_next = ret_address;
                        m_waiting = 0;
                    end
                end else if (take_branch_address) begin
                    q.delete();
                    m_next = branch_address;
                end else if (ret) begin
                    q.delete();
                    m_waiting = 1;
                end else if (m_started) begin
                    q.push_back(int'(m_next));
                    m_next = m_next + 16'd1;
                end
            end
            m_started = 1;
            @(negedge clock);
        end
        stall = 1'b0; take_branch_address = 1'b0; ret = 1'b0; ret_address_valid = 1'b0;
    endtask

    initial begin
        nreset = 1'b0;
        nreset2 = 1'b0;
        stall = 1'b0; take_branch_address = 1'b0; branch_address = '0;
        ret = 1'b0; ret_address_valid = 1'b0; ret_address = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_ret();
        test_reset_mid_ret();
        test_reset_vector_wrap();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
